sevenseg_capture: RTL and testbench

- Receive-side counterpart of the Basys3 4-digit multiplexed display driver.
- Samples the time-multiplexed, active-low an/seg/dp lines and rebuilds the per-digit {dp,seg} codes and digit-enable mask. It tolerates PWM blanking, mux transitions and glitches.
- Used as a loop-back monitor in board self-test, and as a capture block for externally driven multiplexed displays.

---
 rtl/sevenseg_capture.sv | 193 +++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// Capture monitor for a 4-digit multiplexed, active-low seven-segment bus.
// Optional hex decode of the stored glyphs is built when SEVENSEG_CAPTURE_HEX_EN is defined.
module sevenseg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      an,
    input  logic [6:0]      seg,
    input  logic            dp,
    output logic [3:0][7:0] digits,
    output logic [3:0]      digit_en,
    output logic [3:0]      upd,
    output logic [3:0][3:0] hex,
    output logic [3:0]      hex_ok,
    output logic [7:0]      err_cnt
);

    localparam int          TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  STABLE_RC = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    logic [11:0] s1_q, s2_q;
    logic [3:0]  an_s;
    logic [7:0]  code_s;
    logic        blank, valid, illegal;
    logic [1:0]  idx_s;

    state_t      state_q, state_d;
    logic [9:0]  cand_q, cand_d;
    logic [7:0]  rc_q, rc_d;
    logic        same, commit;

    logic [3:0][7:0]    dig_q, dig_d;
    logic [3:0]         en_q, en_d;
    logic [3:0]         upd_q, upd_d;
    logic [3:0][TW-1:0] tmo_q, tmo_d;
    logic [7:0]         err_q, err_d;

    assign an_s   = s2_q[11:8];
    assign code_s = s2_q[7:0];

    always_comb begin
        valid = 1'b1;
        idx_s = 2'd0;
        case (an_s)
            4'b1110: idx_s = 2'd0;
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: valid = 1'b0;
        endcase
    end

    assign blank   = (an_s == 4'b1111);
    assign illegal = !valid && !blank;
    assign same    = (cand_q == {idx_s, code_s});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= {an, dp, seg};
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '1;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            rc_q    <= rc_d;
        end
    end

    // Blank samples fall through with everything held, so PWM off-time never breaks a run.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        rc_d    = rc_q;
        if (illegal) begin
            state_d = IDLE;
            rc_d    = '0;
        end else if (valid) begin
            if (state_q != IDLE && same) begin
                if (state_q == TRACK) begin
                    rc_d = rc_q + 8'd1;
                    if (rc_q + 8'd1 == STABLE_RC) state_d = LOCKED;
                end
            end else begin
                cand_d  = {idx_s, code_s};
                rc_d    = 8'd1;
                state_d = (STABLE_RC == 8'd1) ? LOCKED : TRACK;
            end
        end
    end

    always_comb begin
        commit = 1'b0;
        if (valid) begin
            if (state_q == TRACK && same)
                commit = (rc_q + 8'd1 == STABLE_RC);
            else if (!(state_q != IDLE && same))
                commit = (STABLE_RC == 8'd1);
        end
    end

    // Commit beats timeout; an expired counter parks at the limit until the next commit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig_d[i] = dig_q[i];
            en_d[i]  = en_q[i];
            upd_d[i] = 1'b0;
            tmo_d[i] = tmo_q[i];
            if (commit && idx_s == 2'(i)) begin
                dig_d[i] = code_s;
                en_d[i]  = 1'b1;
                upd_d[i] = 1'b1;
                tmo_d[i] = '0;
            end else if (tmo_q[i] != TLIM) begin
                tmo_d[i] = tmo_q[i] + 1'b1;
                if (tmo_q[i] + 1'b1 == TLIM) begin
                    en_d[i]  = 1'b0;
                    dig_d[i] = 8'hFF;
                end
            end
        end
        err_d = (illegal && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '1;
            en_q  <= '0;
            upd_q <= '0;
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            dig_q <= dig_d;
            en_q  <= en_d;
            upd_q <= upd_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign digits   = dig_q;
    assign digit_en = en_q;
    assign upd      = upd_q;
    assign err_cnt  = err_q;

`ifdef SEVENSEG_CAPTURE_HEX_EN
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_ok[i] = 1'b1;
            case (dig_q[i][6:0])
                7'b1000000: hex[i] = 4'h0;
                7'b1111001: hex[i] = 4'h1;
                7'b0100100: hex[i] = 4'h2;
                7'b0110000: hex[i] = 4'h3;
                7'b0011001: hex[i] = 4'h4;
                7'b0010010: hex[i] = 4'h5;
                7'b0000010: hex[i] = 4'h6;
                7'b1111000: hex[i] = 4'h7;
                7'b0000000: hex[i] = 4'h8;
                7'b0010000: hex[i] = 4'h9;
                7'b0001000: hex[i] = 4'hA;
                7'b0000011: hex[i] = 4'hB;
                7'b1000110: hex[i] = 4'hC;
                7'b0100001: hex[i] = 4'hD;
                7'b0000110: hex[i] = 4'hE;
                7'b0001110: hex[i] = 4'hF;
                default: begin
                    hex[i]    = 4'h0;
                    hex_ok[i] = 1'b0;
                end
            endcase
        end
    end
`else
    assign hex    = '0;
    assign hex_ok = '0;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized bench for sevenseg_capture against a run-length reference model.
module tb_sevenseg_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      an;
    logic [6:0]      seg;
    logic            dp;
    logic [3:0][7:0] digits;
    logic [3:0]      digit_en;
    logic [3:0]      upd;
    logic [3:0][3:0] hex;
    logic [3:0]      hex_ok;
    logic [7:0]      err_cnt;

    sevenseg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
        .digits(digits), .digit_en(digit_en), .upd(upd),
        .hex(hex), .hex_ok(hex_ok), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: two-sample input delay, then "commit when the current run of
    // identical lit samples (blanks skipped) is exactly STABLE long".
    logic [11:0] p1, p2, run_val;
    int          run_len;
    logic [7:0]  m_dig [4];
    bit          m_en  [4];
    bit          m_upd [4];
    int          m_tmo [4];
    int          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        p1 = '1; p2 = '1; run_val = '1; run_len = 0; m_err = 0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 8'hFF; m_en[i] = 0; m_upd[i] = 0; m_tmo[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [11:0] x;
        int          low, ci;
        if (!rst_n) begin
            model_reset();
            return;
        end
        x  = p2;
        p2 = p1;
        p1 = {an, dp, seg};
        ci = -1;
        low = $countones(~x[11:8]);
        if (low > 1) begin
            run_len = 0;
            if (m_err < 255) m_err++;
        end else if (low == 1) begin
            if (run_len > 0 && x == run_val) run_len++;
            else begin run_val = x; run_len = 1; end
            if (run_len == STABLE)
                for (int i = 0; i < 4; i++) if (!x[8+i]) ci = i;
        end
        for (int i = 0; i < 4; i++) begin
            m_upd[i] = 0;
            if (i == ci) begin
                m_dig[i] = x[7:0]; m_en[i] = 1; m_upd[i] = 1; m_tmo[i] = 0;
            end else if (m_tmo[i] != TIMEOUT - 1) begin
                m_tmo[i]++;
                if (m_tmo[i] == TIMEOUT - 1) begin m_en[i] = 0; m_dig[i] = 8'hFF; end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0][7:0] ed;
        logic [3:0][3:0] eh;
        logic [3:0]      ee, eu, eok;
        for (int i = 0; i < 4; i++) begin
            ed[i] = m_dig[i]; ee[i] = m_en[i]; eu[i] = m_upd[i];
            eh[i] = 4'h0; eok[i] = 1'b0;
`ifdef SEVENSEG_CAPTURE_HEX_EN
            for (int g = 0; g < 16; g++)
                if (glyph[g] == m_dig[i][6:0]) begin eh[i] = 4'(g); eok[i] = 1'b1; end
`endif
        end
        chk("digits", 64'(digits), 64'(ed));
        chk("digit_en", 64'(digit_en), 64'(ee));
        chk("upd", 64'(upd), 64'(eu));
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
        chk("hex", 64'(hex), 64'(eh));
        chk("hex_ok", 64'(hex_ok), 64'(eok));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drv(input logic [3:0] a, input logic [6:0] s, input logic d);
        an = a; seg = s; dp = d;
    endtask

    initial begin
        int first, pulses, hold, gap;
        logic [3:0] a;
        logic [6:0] s;
        rst_n = 1'b0;
        drv(4'hF, 7'h7F, 1'b1);
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle: nothing lit for a long stretch.
        repeat (1000) step();

        // Constant digit 0 showing "1": commit latency and single pulse.
        drv(4'b1110, 7'b1111001, 1'b1);
        first = 0; pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (upd[0]) begin pulses++; if (first == 0) first = c; end
        end
        chk("upd_latency", 64'(first), 64'(STABLE + 2));
        chk("upd_pulses", 64'(pulses), 64'd1);
        chk("dig0_F9", 64'(digits[0]), 64'hF9);
        chk("en_0001", 64'(digit_en), 64'b0001);

        // Digit 1 "A" with a blank every fourth cycle.
        for (int r = 0; r < 5; r++) begin
            drv(4'b1101, 7'b0001000, 1'b1);
            repeat (3) step();
            drv(4'hF, 7'h7F, 1'b1);
            step();
        end
        chk("dig1_88", 64'(digits[1]), 64'h88);

        // Digit 2 flipping every 3 cycles never commits.
        for (int r = 0; r < 10; r++) begin
            drv(4'b1011, (r % 2) ? 7'b0100100 : 7'b0110000, 1'b1);
            repeat (3) step();
        end
        chk("en2_quiet", 64'(digit_en[2]), 64'd0);

        // Illegal double-anode injections saturate the error counter.
        for (int r = 0; r < 300; r++) begin
            drv(4'b0111, 7'b0010010, 1'b0);
            repeat (2) step();
            drv(4'b1100, 7'b0000000, 1'b1);
            step();
        end
        repeat (3) step();
        chk("err_sat", 64'(err_cnt), 64'd255);

        // Digit 3 recommits at gaps around the timeout edge, then expires.
        for (int g = 0; g < 12; g++) begin
            gap = 50 + g;
            drv(4'b0111, (g % 2) ? 7'b1111000 : 7'b0010010, 1'b1);
            repeat (8) step();
            drv(4'hF, 7'h7F, 1'b1);
            repeat (gap) step();
        end
        repeat (70) step();
        chk("en3_timeout", 64'(digit_en[3]), 64'd0);
        chk("dig3_FF", 64'(digits[3]), 64'hFF);

        // Reset mid-run drops the candidate without a pulse.
        drv(4'b1110, 7'b0000110, 1'b1);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        drv(4'hF, 7'h7F, 1'b1);
        repeat (10) step();

        // Random mix of digits, blanks and rare illegal samples.
        for (int r = 0; r < 400; r++) begin
            hold = $urandom_range(1, 7);
            a = 4'hF;
            a[$urandom_range(0, 3)] = 1'b0;
            s = glyph[$urandom_range(0, 3) * 5];
            dp = 1'($urandom_range(0, 1));
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 99) < 2) an = 4'b0000;
                else if ($urandom_range(0, 99) < 15) an = 4'hF;
                else an = a;
                seg = s;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
